// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types and constants: default operand width and
// the state encoding of the bit-serial subtractor.
package arith_pkg;

  localparam int ARITH_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_sub_state_t;

endpackage

// File: rtl/serial_subtractor_16bit_full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bi, with bo set when that
// subtraction needs a borrow from the next bit.
module full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = x_i ^ y_i ^ bi_i;
  assign bo_o = (~x_i & y_i) | (~(x_i ^ y_i) & bi_i);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor computing a - b - bin LSB first through one cell.
// Optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
module serial_subtractor_16bit
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_sub_state_t state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  diff_q;
  logic [WIDTH-1:0]  diff_d;
  logic              borrow_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              cell_d;
  logic              cell_bo;
`ifdef SERIAL_SUB_OVF_EN
  logic              a_msb_q;
  logic              b_msb_q;
  logic              ovf_q;
`endif

  full_subtractor u_cell (
    .x_i  (a_q[0]),
    .y_i  (b_q[0]),
    .bi_i (borrow_q),
    .d_o  (cell_d),
    .bo_o (cell_bo)
  );

  // Result fills from the top so bit 0 ends up at the LSB after WIDTH shifts.
  assign diff_d = {cell_d, diff_q[WIDTH-1:1]};
  assign cnt_d  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            a_q        <= a_i;
            b_q        <= b_i;
            borrow_q   <= bin_i;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q    <= a_i[WIDTH-1];
            b_msb_q    <= b_i[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_q      <= {1'b0, a_q[WIDTH-1:1]};
          b_q      <= {1'b0, b_q[WIDTH-1:1]};
          diff_q   <= diff_d;
          borrow_q <= cell_bo;
          cnt_q    <= cnt_d;
          if (cnt_q == LAST_BIT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // The bit produced this cycle is the result sign bit.
            ovf_q       <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign diff_o      = diff_q;
  assign bout_o      = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule
